// File: rtl/decode_arb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : decode_arb_ctrl
//  Description : Round-robin arbiter over NUM_HARTS instruction sources feeding
//                a single-entry registered RV32I control decoder with a
//                valid/ready output handshake.
//                Optional feature macro: DECODE_ARB_ILLEGAL_TRAP_EN enables
//                illegal-instruction detection (illegal output, side-effect
//                controls suppressed).
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_arb_ctrl #(
    parameter int NUM_HARTS = 2,
    localparam int HID_W    = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_HARTS-1:0]    in_valid,
    input  logic [32*NUM_HARTS-1:0] in_instr,
    output logic [NUM_HARTS-1:0]    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [HID_W-1:0]        out_hart,
    output logic [3:0]              alu_op,
    output logic [2:0]              mask,
    output logic [2:0]              br_type,
    output logic [1:0]              wb_sel,
    output logic                    reg_wr,
    output logic                    sel_A,
    output logic                    sel_B,
    output logic                    rd_en,
    output logic                    wr_en,
    output logic                    jump,
    output logic                    illegal
);

    localparam logic [6:0] c_OP_RTYPE = 7'b0110011;
    localparam logic [6:0] c_OP_IALU  = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [2:0] mask;
        logic [2:0] br_type;
        logic [1:0] wb_sel;
        logic       reg_wr;
        logic       sel_A;
        logic       sel_B;
        logic       rd_en;
        logic       wr_en;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    logic [HID_W-1:0]     r_last_grant;
    logic                 r_out_valid;
    logic [HID_W-1:0]     r_out_hart;
    ctrl_t                r_bundle;

    logic                 w_stage_accept;
    logic                 w_grant_found;
    logic [HID_W-1:0]     w_grant_idx;
    logic [HID_W:0]       w_rr_sum;
    logic [NUM_HARTS-1:0] w_grant_onehot;
    logic                 w_xfer;
    logic [31:0]          w_sel_instr;
    logic [6:0]           w_opcode;
    logic [2:0]           w_func3;
    logic [6:0]           w_func7;
    logic                 w_alt;
    logic [3:0]           w_alu_r;
    logic [3:0]           w_alu_i;
    ctrl_t                w_dec;
    logic                 w_unused_instr_bits;

    // The single output register can take a new bundle when empty or retiring.
    assign w_stage_accept = !r_out_valid || out_ready;
    assign w_xfer         = w_grant_found && w_stage_accept;
    assign w_grant_onehot = NUM_HARTS'(1) << w_grant_idx;
    assign in_ready       = (w_xfer && !reset) ? w_grant_onehot : '0;

    // Round-robin search starting one past the last accepted hart, with wrap.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_rr_sum      = '0;
        for (int k = 1; k <= NUM_HARTS; k++) begin
            w_rr_sum = {1'b0, r_last_grant} + (HID_W+1)'(k);
            if (w_rr_sum >= (HID_W+1)'(NUM_HARTS)) begin
                w_rr_sum = w_rr_sum - (HID_W+1)'(NUM_HARTS);
            end
            if (!w_grant_found && in_valid[w_rr_sum[HID_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_rr_sum[HID_W-1:0];
            end
        end
    end

    // Mux the granted hart's instruction word into the decoder.
    always_comb begin
        w_sel_instr = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (w_grant_idx == HID_W'(h)) begin
                w_sel_instr = in_instr[32*h +: 32];
            end
        end
    end

    assign w_opcode            = w_sel_instr[6:0];
    assign w_func3             = w_sel_instr[14:12];
    assign w_func7             = w_sel_instr[31:25];
    assign w_alt               = (w_func7 == 7'b0100000);
    assign w_unused_instr_bits = ^{w_sel_instr[24:15], w_sel_instr[11:7]};

    // ALU operation table; func7 alternate selects sub (R-type only) and sra.
    always_comb begin
        w_alu_r = 4'd0;
        case (w_func3)
            3'b000:  w_alu_r = w_alt ? 4'd9 : 4'd0;
            3'b001:  w_alu_r = 4'd1;
            3'b010:  w_alu_r = 4'd2;
            3'b011:  w_alu_r = 4'd3;
            3'b100:  w_alu_r = 4'd4;
            3'b101:  w_alu_r = w_alt ? 4'd6 : 4'd5;
            3'b110:  w_alu_r = 4'd7;
            default: w_alu_r = 4'd8;
        endcase
        // Immediate ALU ops have no subtract; func3 000 is always add.
        w_alu_i = (w_func3 == 3'b000) ? 4'd0 : w_alu_r;
    end

    // Opcode decode into the control bundle; unknown opcodes leave all zero.
    always_comb begin
        w_dec = '0;
        case (w_opcode)
            c_OP_RTYPE: begin
                w_dec.reg_wr = 1'b1;
                w_dec.sel_A  = 1'b1;
                w_dec.alu_op = w_alu_r;
            end
            c_OP_IALU: begin
                w_dec.reg_wr = 1'b1;
                w_dec.sel_A  = 1'b1;
                w_dec.sel_B  = 1'b1;
                w_dec.alu_op = w_alu_i;
            end
            c_OP_LOAD: begin
                w_dec.reg_wr = 1'b1;
                w_dec.sel_A  = 1'b1;
                w_dec.sel_B  = 1'b1;
                w_dec.rd_en  = 1'b1;
                w_dec.wb_sel = 2'd1;
                w_dec.mask   = w_func3;
            end
            c_OP_STORE: begin
                w_dec.sel_A  = 1'b1;
                w_dec.sel_B  = 1'b1;
                w_dec.wr_en  = 1'b1;
                w_dec.mask   = w_func3;
            end
            c_OP_BR: begin
                w_dec.sel_B   = 1'b1;
                w_dec.br_type = w_func3;
            end
            c_OP_LUI: begin
                w_dec.reg_wr = 1'b1;
                w_dec.sel_A  = 1'b1;
                w_dec.sel_B  = 1'b1;
                w_dec.alu_op = 4'd10;
            end
            c_OP_AUIPC: begin
                w_dec.reg_wr = 1'b1;
                w_dec.sel_B  = 1'b1;
            end
            c_OP_JAL: begin
                w_dec.reg_wr = 1'b1;
                w_dec.sel_B  = 1'b1;
                w_dec.wb_sel = 2'd2;
                w_dec.jump   = 1'b1;
            end
            c_OP_JALR: begin
                w_dec.reg_wr = 1'b1;
                w_dec.sel_A  = 1'b1;
                w_dec.sel_B  = 1'b1;
                w_dec.wb_sel = 2'd2;
                w_dec.jump   = 1'b1;
            end
            default: w_dec = '0;
        endcase

`ifdef DECODE_ARB_ILLEGAL_TRAP_EN
        case (w_opcode)
            c_OP_RTYPE: w_dec.illegal = !((w_func7 == 7'b0000000) || w_alt);
            c_OP_BR:    w_dec.illegal = (w_func3 == 3'b010) || (w_func3 == 3'b011);
            c_OP_LOAD:  w_dec.illegal = (w_func3 == 3'b011) || (w_func3 == 3'b110) ||
                                        (w_func3 == 3'b111);
            c_OP_STORE: w_dec.illegal = (w_func3 >= 3'b011);
            c_OP_IALU, c_OP_LUI, c_OP_AUIPC, c_OP_JAL, c_OP_JALR:
                        w_dec.illegal = 1'b0;
            default:    w_dec.illegal = 1'b1;
        endcase
        // An illegal instruction must not cause any architectural side effect.
        if (w_dec.illegal) begin
            w_dec.reg_wr = 1'b0;
            w_dec.rd_en  = 1'b0;
            w_dec.wr_en  = 1'b0;
            w_dec.jump   = 1'b0;
        end
`else
        w_dec.illegal = 1'b0;
`endif
    end

    // Output register and round-robin pointer; both move only on a transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_hart   <= '0;
            r_bundle     <= '0;
            r_last_grant <= HID_W'(NUM_HARTS - 1);
        end else if (w_xfer) begin
            r_out_valid  <= 1'b1;
            r_out_hart   <= w_grant_idx;
            r_bundle     <= w_dec;
            r_last_grant <= w_grant_idx;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_hart  = r_out_hart;
    assign alu_op    = r_bundle.alu_op;
    assign mask      = r_bundle.mask;
    assign br_type   = r_bundle.br_type;
    assign wb_sel    = r_bundle.wb_sel;
    assign reg_wr    = r_bundle.reg_wr;
    assign sel_A     = r_bundle.sel_A;
    assign sel_B     = r_bundle.sel_B;
    assign rd_en     = r_bundle.rd_en;
    assign wr_en     = r_bundle.wr_en;
    assign jump      = r_bundle.jump;
    assign illegal   = r_bundle.illegal;

endmodule
`default_nettype wire
